// File: rtl/booth_divider_seq.sv
// -----------------------------------------------------------------------------
// booth_divider_seq
//
// Sequential signed two's-complement divider, the companion of the Booth
// multiplier. A request is accepted on start while idle. The divider then runs
// WIDTH restoring-division steps on the operand magnitudes, one per clock, and
// finishes with one sign-correction cycle. The result is returned with a
// one-cycle done pulse.
//
// Results: the quotient truncates toward zero and the remainder takes the sign
// of the dividend. MIN / -1 wraps to quotient = MIN and remainder = 0. Division
// by zero returns an all-ones quotient, returns the dividend as the remainder,
// and raises div_by_zero.
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous, active-high reset (clears every register)
//   start        request strobe, sampled only while idle
//   dividend     signed dividend, captured at the accepting edge
//   divisor      signed divisor, captured at the accepting edge
//   quotient     signed quotient, registered, held until the next result
//   remainder    signed remainder, registered, held until the next result
//   busy         high while an operation is in progress
//   done         one-cycle pulse, outputs valid in that cycle
//   div_by_zero  registered with done, high if the divisor was zero;
//                cleared by the next accepted start
// -----------------------------------------------------------------------------
module booth_divider_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int             CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // Two's-complement negation, truncated to WIDTH bits.
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        negate = {WIDTH{1'b0}} - v;
    endfunction

    // Unsigned magnitude. |MIN| = 2^(WIDTH-1) is still representable unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        if (v[WIDTH-1]) begin
            magnitude = negate(v);
        end else begin
            magnitude = v;
        end
    endfunction

    state_t           state_q,       state_d;
    logic             neg_quo_q,     neg_quo_d;     // quotient needs negation
    logic             neg_rem_q,     neg_rem_d;     // remainder needs negation
    logic             dz_q,          dz_d;          // current op divides by zero
    logic [WIDTH-1:0] dvd_q,         dvd_d;         // raw dividend, for the dz remainder
    logic [WIDTH-1:0] quo_q,         quo_d;         // |dividend| shifting out, quotient bits shifting in
    logic [WIDTH-1:0] dsr_q,         dsr_d;         // |divisor|
    logic [WIDTH:0]   part_q,        part_d;        // partial remainder P
    logic [CW-1:0]    count_q,       count_d;
    logic [WIDTH-1:0] quotient_q,    quotient_d;
    logic [WIDTH-1:0] remainder_q,   remainder_d;
    logic             busy_q,        busy_d;
    logic             done_q,        done_d;
    logic             div_by_zero_q, div_by_zero_d;

    logic [WIDTH+1:0] shifted_s;   // {P, next dividend bit}, one extra bit of headroom
    logic [WIDTH+1:0] trial_s;     // shifted_s - |divisor|; the MSB is the borrow

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d       = state_q;
        neg_quo_d     = neg_quo_q;
        neg_rem_d     = neg_rem_q;
        dz_d          = dz_q;
        dvd_d         = dvd_q;
        quo_d         = quo_q;
        dsr_d         = dsr_q;
        part_d        = part_q;
        count_d       = count_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        div_by_zero_d = div_by_zero_q;

        shifted_s = {part_q, quo_q[WIDTH-1]};
        trial_s   = shifted_s - {2'b00, dsr_q};

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    neg_quo_d     = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    neg_rem_d     = dividend[WIDTH-1];
                    dvd_d         = dividend;
                    quo_d         = magnitude(dividend);
                    dsr_d         = magnitude(divisor);
                    part_d        = {(WIDTH + 1){1'b0}};
                    count_d       = {CW{1'b0}};
                    dz_d          = (divisor == {WIDTH{1'b0}});
                    div_by_zero_d = 1'b0;
                    busy_d        = 1'b1;
                    if (divisor == {WIDTH{1'b0}}) begin
                        state_d = ST_FIX;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    busy_d = 1'b0;
                end
            end

            ST_RUN: begin
                busy_d = 1'b1;
                // A clear borrow means the trial subtraction fits.
                // Otherwise P is restored to the shifted value.
                if (!trial_s[WIDTH+1]) begin
                    part_d = trial_s[WIDTH:0];
                    quo_d  = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    part_d = shifted_s[WIDTH:0];
                    quo_d  = {quo_q[WIDTH-2:0], 1'b0};
                end
                count_d = count_q + {{(CW - 1){1'b0}}, 1'b1};
                if (count_q == LAST_STEP) begin
                    state_d = ST_FIX;
                end else begin
                    state_d = ST_RUN;
                end
            end

            ST_FIX: begin
                if (dz_q) begin
                    quotient_d    = {WIDTH{1'b1}};
                    remainder_d   = dvd_q;
                    div_by_zero_d = 1'b1;
                end else begin
                    // MIN / -1 lands here as quo_q = 2^(WIDTH-1), so it wraps to MIN.
                    if (neg_quo_q) begin
                        quotient_d = negate(quo_q);
                    end else begin
                        quotient_d = quo_q;
                    end
                    if (neg_rem_q) begin
                        remainder_d = negate(part_q[WIDTH-1:0]);
                    end else begin
                        remainder_d = part_q[WIDTH-1:0];
                    end
                    div_by_zero_d = 1'b0;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset; every flop is cleared on reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            neg_quo_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            dz_q          <= 1'b0;
            dvd_q         <= {WIDTH{1'b0}};
            quo_q         <= {WIDTH{1'b0}};
            dsr_q         <= {WIDTH{1'b0}};
            part_q        <= {(WIDTH + 1){1'b0}};
            count_q       <= {CW{1'b0}};
            quotient_q    <= {WIDTH{1'b0}};
            remainder_q   <= {WIDTH{1'b0}};
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            neg_quo_q     <= neg_quo_d;
            neg_rem_q     <= neg_rem_d;
            dz_q          <= dz_d;
            dvd_q         <= dvd_d;
            quo_q         <= quo_d;
            dsr_q         <= dsr_d;
            part_q        <= part_d;
            count_q       <= count_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_booth_divider_seq.sv
// -----------------------------------------------------------------------------
// tb_booth_divider_seq
//
// Self-checking bench for booth_divider_seq with WIDTH = 4.
//
// Each accepted request pushes its expected result onto a queue. Expected
// values come from integer / and %, or from the divide-by-zero rule.
// Every done pulse pops one entry and checks quotient, remainder,
// div_by_zero and latency. Sequence-level checks (reset state, busy length,
// ignored start, mid-operation reset) run in the main stimulus block.
// -----------------------------------------------------------------------------
module tb_booth_divider_seq;

    localparam int W = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    booth_divider_seq #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    // 10 time-unit clock.
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Edge counter used for latency measurement.
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           acc;
        int           lat;
    } exp_t;

    exp_t sb[$];

    // Single comparison point: counts and reports.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    // Scoreboard monitor: compare on every done pulse, away from the active edge.
    always @(negedge clock) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
                chk("div_by_zero", div_by_zero, e.dz);
                chk("latency", cyc - e.acc, e.lat);
                chk("busy_in_done", busy, 0);
            end
        end
    end

    // Drive one request (caller guarantees the DUT is idle) and record the expectation.
    task automatic do_op(input int a, input int b);
        exp_t e;
        start    = 1'b1;
        dividend = a[W-1:0];
        divisor  = b[W-1:0];
        @(posedge clock);
        #1;
        start = 1'b0;
        e.acc = cyc;
        if (b == 0) begin
            e.q   = '1;
            e.r   = a[W-1:0];
            e.dz  = 1'b1;
            e.lat = 1;
        end else begin
            e.q   = W'(a / b);
            e.r   = W'(a % b);
            e.dz  = 1'b0;
            e.lat = W + 1;
        end
        sb.push_back(e);
    endtask

    // Wait (bounded) for done; return the number of busy cycles seen before it.
    task automatic wait_done(output int bc);
        bit seen;
        seen = 1'b0;
        bc   = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clock);
            if (done === 1'b1) seen = 1'b1;
            else if (busy === 1'b1) bc++;
        end
        if (!seen) chk("done_timeout", seen, 1);
    endtask

    int ta[6] = '{-7,  7, -7, -8, -8, 3};
    int tb[6] = '{ 2, -2, -2, -1,  1, 5};

    initial begin
        int bc;
        int dcount;

        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quot", quotient, 0);
        chk("rst_rem", remainder, 0);
        chk("rst_dz", div_by_zero, 0);
        reset = 1'b0;
        @(negedge clock);

        // 7 / 2: basic result, latency and busy length.
        do_op(7, 2);
        wait_done(bc);
        chk("busy_len", bc, 5);

        // Sign and corner cases, each started in the previous done cycle.
        for (int i = 0; i < 6; i++) begin
            do_op(ta[i], tb[i]);
            wait_done(bc);
            chk("busy_len_b2b", bc, 5);
        end

        // Divide by zero, then a fresh start clears the flag but the outputs hold.
        do_op(5, 0);
        wait_done(bc);
        chk("dz_busy_len", bc, 1);
        do_op(3, 5);
        @(negedge clock);
        chk("dz_cleared", div_by_zero, 0);
        chk("quot_held", quotient, 4'hF);
        chk("rem_held", remainder, 4'h5);
        wait_done(bc);

        // start while busy is ignored.
        do_op(6, 3);
        @(negedge clock);
        @(negedge clock);
        start    = 1'b1;
        dividend = 4'd1;
        divisor  = 4'd1;
        @(negedge clock);
        start = 1'b0;
        wait_done(bc);
        chk("ignore_busy_len", bc, 2);

        // Back-to-back: 5 / 2 started in the done cycle.
        do_op(5, 2);
        wait_done(bc);
        chk("b2b_busy_len", bc, 5);

        // Reset at the 3rd RUN edge aborts the operation.
        do_op(-7, 3);
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        sb.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_quot", quotient, 0);
        chk("mid_rst_rem", remainder, 0);
        chk("mid_rst_dz", div_by_zero, 0);
        dcount = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (done === 1'b1) dcount++;
        end
        chk("no_done_after_rst", dcount, 0);

        do_op(4, 2);
        wait_done(bc);
        chk("post_rst_busy_len", bc, 5);

        repeat (2) @(negedge clock);
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/booth_divider_seq.md
Name: booth_divider_seq

Overview:
- Sequential signed two's-complement divider; the inverse of the team's Booth multiplier.
- Accepts dividend/divisor on a start strobe and runs one restoring-division step per clock on operand magnitudes.
- Applies sign correction at the end and returns quotient/remainder with a one-cycle done pulse.
- Sits next to the multiplier in the datapath; shares its operand width and the reset style.

Parameters:
- WIDTH, 4, operand/result width in bits (≥2); dividend, divisor, quotient and remainder are all WIDTH bits, signed.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only while idle
- dividend  input  WIDTH  signed dividend, captured at the accepting edge
- divisor  input  WIDTH  signed divisor, captured at the accepting edge
- quotient  output  WIDTH  signed quotient, registered; held until the next result
- remainder  output  WIDTH  signed remainder, registered; held until the next result
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse; outputs are valid in that cycle
- div_by_zero  output  1  registered with done; high if the divisor was 0

Behaviour:
- Reset: clock is clock; reset is reset, synchronous, active-high.
  - On reset: state=IDLE; quotient=0, remainder=0; busy=0, done=0, div_by_zero=0.
  - All internal registers are cleared.
  - Reset mid-operation aborts the operation with no done pulse.
- States: IDLE, RUN, FIX.
- IDLE:
  - busy=0. done=0 except in the cycle directly after the FIX edge.
  - start=1 at an edge accepts the request:
    - captures sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend);
    - captures the magnitudes |dividend| and |divisor| as WIDTH-bit unsigned (|MIN| = 2^(WIDTH-1) fits);
    - clears the WIDTH+1-bit partial remainder P and sets count=0.
  - If divisor==0, the next state is FIX with the dz flag set; otherwise the next state is RUN.
- RUN (busy=1), one step per edge:
  - Shift {P, Qreg} left by 1; trial = P - |divisor|.
  - If trial ≥ 0: P=trial and Qreg[0]=1. Otherwise P is restored and Qreg[0]=0.
  - count increments. After the WIDTH-th step the next state is FIX.
- FIX (busy=1), one edge:
  - quotient = sign_q ? -Qreg : Qreg; remainder = sign_r ? -P[WIDTH-1:0] : P[WIDTH-1:0]. Both are truncated to WIDTH bits.
  - done=1 in the following cycle; next state is IDLE.
  - In the dz case: quotient = all ones, remainder = captured dividend, div_by_zero=1.
- Latency, counting the accepting edge as edge 1:
  - normal operation: done is high in the cycle after edge WIDTH+2;
  - divide by zero: done is high in the cycle after edge 2.
- busy goes high after the accepting edge and low in the done cycle.
- Arithmetic:
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - |remainder| < |divisor|, and dividend = quotient*divisor + remainder.
- Overflow (MIN / -1): the result wraps; quotient = MIN (100…0), remainder = 0, div_by_zero=0. There is no extra flag.
- start while busy is ignored: operands are not re-captured and the running operation is unaffected.
- start in the done cycle (state is IDLE) is accepted; back-to-back operations are legal.
- div_by_zero stays valid until the next accepted start, which clears it at the accepting edge. quotient and remainder hold their value until the next FIX edge.

Test Plan (WIDTH=4):
- Unsigned-like case: 7 / 2 → done 6 cycles after the accepting edge, quotient=4'b0011, remainder=4'b0001, div_by_zero=0. busy is high for exactly 5 cycles.
- Sign cases:
  - -7 / 2 → quotient=4'b1101 (-3), remainder=4'b1111 (-1);
  - 7 / -2 → quotient=4'b1101, remainder=4'b0001;
  - -7 / -2 → quotient=4'b0011, remainder=4'b1111.
- Corner values:
  - -8 / -1 → quotient=4'b1000, remainder=0;
  - -8 / 1 → quotient=4'b1000, remainder=0;
  - 3 / 5 → quotient=0, remainder=4'b0011.
- Divide by zero: 5 / 0 → done in the cycle after edge 2, div_by_zero=1, quotient=4'b1111, remainder=4'b0101. The next accepted start clears div_by_zero.
- Busy/back-to-back:
  - start 6/3; pulse start with 1/1 during RUN → result quotient=2, remainder=0, and the second request is ignored;
  - assert start with 5/2 in the done cycle → second done 6 cycles later with quotient=2, remainder=1.
- Reset mid-operation: start -7/3; assert reset at the 3rd RUN edge → next cycle busy=0, done=0, quotient=0, remainder=0. No done pulse follows, and a fresh 4/2 gives quotient=2, remainder=0.
